// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcodes, ALU codes, state encoding and instruction fields for control_unit
package control_pkg;

    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_LD   = 4'b1001;
    localparam logic [3:0] OP_ST   = 4'b1010;
    localparam logic [3:0] OP_JMP  = 4'b1011;
    localparam logic [3:0] OP_JZ   = 4'b1100;
    localparam logic [3:0] OP_JC   = 4'b1101;
    localparam logic [3:0] OP_JN   = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD    = 3'b000;
    localparam logic [2:0] ALU_SUB    = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;
    localparam logic [2:0] ALU_PASS_B = 3'b100;

    localparam int OPC_LSB = 12;
    localparam int DST_LSB = 10;
    localparam int A_LSB   = 8;
    localparam int B_LSB   = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    typedef struct packed {
        logic       load_enable;
        logic [2:0] operation_select;
        logic [1:0] a_select;
        logic [1:0] b_select;
        logic [1:0] destination_select;
        logic [7:0] constant_in;
        logic       mb_select;
        logic       md_select;
        logic       write_ram_enable;
    } ctrl_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
    } flags_t;

    // Opcodes whose result flags are latched: ALU reg-reg, LDI and LD.
    function automatic logic captures_flags(input logic [3:0] opcode);
        return (opcode[3] == 1'b0) || (opcode == OP_LDI) || (opcode == OP_LD);
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - combinational instruction word to data_unit control vector
module instruction_decoder
    import control_pkg::*;
(
    input  logic        enable_i,
    input  logic [15:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [3:0] opcode;
    assign opcode = instr_i[OPC_LSB +: 4];

    always_comb begin
        ctrl_o = '0;
        if (enable_i) begin
            if (opcode[3] == 1'b0) begin
                ctrl_o.load_enable        = 1'b1;
                ctrl_o.operation_select   = opcode[2:0];
                ctrl_o.a_select           = instr_i[A_LSB +: 2];
                ctrl_o.b_select           = instr_i[B_LSB +: 2];
                ctrl_o.destination_select = instr_i[DST_LSB +: 2];
            end else begin
                case (opcode)
                    OP_LDI: begin
                        ctrl_o.load_enable        = 1'b1;
                        ctrl_o.operation_select   = ALU_PASS_B;
                        ctrl_o.mb_select          = 1'b1;
                        ctrl_o.constant_in        = instr_i[IMM_LSB +: 8];
                        ctrl_o.destination_select = instr_i[DST_LSB +: 2];
                    end
                    OP_LD: begin
                        ctrl_o.load_enable        = 1'b1;
                        ctrl_o.md_select          = 1'b1;
                        ctrl_o.a_select           = instr_i[A_LSB +: 2];
                        ctrl_o.b_select           = instr_i[B_LSB +: 2];
                        ctrl_o.destination_select = instr_i[DST_LSB +: 2];
                    end
                    OP_ST: begin
                        ctrl_o.write_ram_enable = 1'b1;
                        ctrl_o.a_select         = instr_i[A_LSB +: 2];
                        ctrl_o.b_select         = instr_i[B_LSB +: 2];
                    end
                    default: ctrl_o = '0;
                endcase
            end
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - FETCH/EXECUTE/HALT sequencer; CONTROL_UNIT_RETIRE_COUNT_EN adds retired_count
module control_unit
    import control_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    output logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    input  logic                   zero_flag,
    input  logic                   carrier_flag,
    input  logic                   negative_flag,
    output logic                   load_enable,
    output logic [2:0]             operation_select,
    output logic [1:0]             a_select,
    output logic [1:0]             b_select,
    output logic [1:0]             destination_select,
    output logic [7:0]             constant_in,
    output logic                   mb_select,
    output logic                   md_select,
    output logic                   write_ram_enable,
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
    output logic                   halted,
    output logic [15:0]            retired_count
`else
    output logic                   halted
`endif
);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    flags_t              flags_q, flags_d;
    ctrl_t               ctrl;
    logic [3:0]          opcode;
    logic [PC_WIDTH-1:0] target;

    assign opcode = prog_data[OPC_LSB +: 4];
    assign target = PC_WIDTH'(prog_data[IMM_LSB +: 8]);

    instruction_decoder u_decoder (
        .enable_i (state_q == ST_EXECUTE),
        .instr_i  (prog_data[15:0]),
        .ctrl_o   (ctrl)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flags_d = flags_q;
        case (state_q)
            ST_FETCH: begin
                if (run) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
                // Conditional jumps test the flags latched before this instruction.
                case (opcode)
                    OP_JMP:  pc_d = target;
                    OP_JZ:   pc_d = flags_q.z ? target : pc_q + PC_WIDTH'(1);
                    OP_JC:   pc_d = flags_q.c ? target : pc_q + PC_WIDTH'(1);
                    OP_JN:   pc_d = flags_q.n ? target : pc_q + PC_WIDTH'(1);
                    OP_HALT: pc_d = pc_q;
                    default: pc_d = pc_q + PC_WIDTH'(1);
                endcase
                if (captures_flags(opcode)) begin
                    flags_d = '{z: zero_flag, c: carrier_flag, n: negative_flag};
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    assign prog_addr          = pc_q;
    assign halted             = (state_q == ST_HALT);
    assign load_enable        = ctrl.load_enable;
    assign operation_select   = ctrl.operation_select;
    assign a_select           = ctrl.a_select;
    assign b_select           = ctrl.b_select;
    assign destination_select = ctrl.destination_select;
    assign constant_in        = ctrl.constant_in;
    assign mb_select          = ctrl.mb_select;
    assign md_select          = ctrl.md_select;
    assign write_ram_enable   = ctrl.write_ram_enable;

`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
    logic [15:0] retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (state_q == ST_EXECUTE) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed scoreboard bench for control_unit with a synchronous program ROM
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;
    logic        zero_flag, carrier_flag, negative_flag;
    logic        load_enable;
    logic [2:0]  operation_select;
    logic [1:0]  a_select, b_select, destination_select;
    logic [7:0]  constant_in;
    logic        mb_select, md_select, write_ram_enable;
    logic        halted;
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
    logic [15:0] retired_count;
`endif

    control_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .run                (run),
        .prog_addr          (prog_addr),
        .prog_data          (prog_data),
        .zero_flag          (zero_flag),
        .carrier_flag       (carrier_flag),
        .negative_flag      (negative_flag),
        .load_enable        (load_enable),
        .operation_select   (operation_select),
        .a_select           (a_select),
        .b_select           (b_select),
        .destination_select (destination_select),
        .constant_in        (constant_in),
        .mb_select          (mb_select),
        .md_select          (md_select),
        .write_ram_enable   (write_ram_enable),
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
        .halted             (halted),
        .retired_count      (retired_count)
`else
        .halted             (halted)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk) prog_data <= rom[prog_addr];

    logic [20:0] obs_ctrl;
    assign obs_ctrl = {load_enable, operation_select, a_select, b_select, destination_select,
                       constant_in, mb_select, md_select, write_ram_enable};

    int          n_total = 0;
    int          n_pass  = 0;
    logic [20:0] sb [$];
    logic [7:0]  pc_m;
    logic        z_m, c_m, n_m;
    logic [15:0] cnt_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [20:0] exp_ctrl(input logic [15:0] w);
        logic       le, mb, md, wr;
        logic [2:0] os;
        logic [1:0] a, b, d;
        logic [7:0] k;
        logic [3:0] op;
        op = w[15:12];
        {le, mb, md, wr, os, a, b, d, k} = '0;
        if (!op[3]) begin
            le = 1; os = op[2:0]; a = w[9:8]; b = w[7:6]; d = w[11:10];
        end else if (op == 4'h8) begin
            le = 1; os = 3'b100; mb = 1; k = w[7:0]; d = w[11:10];
        end else if (op == 4'h9) begin
            le = 1; md = 1; a = w[9:8]; b = w[7:6]; d = w[11:10];
        end else if (op == 4'hA) begin
            wr = 1; a = w[9:8]; b = w[7:6];
        end
        return {le, os, a, b, d, k, mb, md, wr};
    endfunction

    task automatic check_retired();
`ifdef CONTROL_UNIT_RETIRE_COUNT_EN
        check("retired_count", retired_count, cnt_m);
`endif
    endtask

    task automatic model_reset();
        pc_m = 8'h00; z_m = 0; c_m = 0; n_m = 0; cnt_m = 16'd0;
    endtask

    // Called at a negedge while in FETCH with run=1; returns at the negedge of the next FETCH.
    task automatic exec_one(input string tag);
        logic [15:0] w;
        logic [3:0]  op;
        logic [20:0] e;
        w  = rom[pc_m];
        op = w[15:12];
        sb.push_back(exp_ctrl(w));
        @(posedge clk); @(negedge clk);
        e = sb.pop_front();
        check({tag, "_ctrl"}, obs_ctrl, e);
        case (op)
            4'hB:    pc_m = w[7:0];
            4'hC:    pc_m = z_m ? w[7:0] : pc_m + 8'd1;
            4'hD:    pc_m = c_m ? w[7:0] : pc_m + 8'd1;
            4'hE:    pc_m = n_m ? w[7:0] : pc_m + 8'd1;
            4'hF:    pc_m = pc_m;
            default: pc_m = pc_m + 8'd1;
        endcase
        if (op <= 4'h9) begin
            z_m = zero_flag; c_m = carrier_flag; n_m = negative_flag;
        end
        cnt_m = cnt_m + 16'd1;
        @(posedge clk); @(negedge clk);
        check({tag, "_pc"}, prog_addr, pc_m);
        check({tag, "_halted"}, halted, op == 4'hF);
        check_retired();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        #1;
        check("rst_ctrl", obs_ctrl, 21'd0);
        check("rst_pc", prog_addr, 8'h00);
        check("rst_halted", halted, 1'b0);
        model_reset();
        check_retired();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        rom[8'h00] = 16'h800A;
        rom[8'h01] = 16'h0040;
        rom[8'h02] = 16'hC010;
        rom[8'h03] = 16'hF000;
        rom[8'h10] = 16'hA040;
        rom[8'h11] = 16'h9040;
        rom[8'h12] = 16'hD020;
        rom[8'h20] = 16'hE030;
        rom[8'h21] = 16'hB0FF;
        rom[8'hFF] = 16'h8405;
        reset = 1; run = 0;
        zero_flag = 0; carrier_flag = 0; negative_flag = 0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        run = 1;

        exec_one("ldi");
        zero_flag = 1;
        exec_one("add_z1");
        zero_flag = 0;
        exec_one("jz_taken");
        exec_one("st");
        carrier_flag = 1;
        exec_one("ld");
        carrier_flag = 0;
        exec_one("jc_taken");
        exec_one("jn_not_taken");
        exec_one("jmp_ff");
        exec_one("ldi_wrap");

        run = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_pc", prog_addr, pc_m);
            check("hold_ctrl", obs_ctrl, 21'd0);
        end
        run = 1;

        exec_one("ldi2");
        exec_one("add_z0");
        exec_one("jz_not_taken");
        exec_one("halt");
        for (int i = 0; i < 10; i++) begin
            run = ~run;
            @(posedge clk); @(negedge clk);
            check("halt_halted", halted, 1'b1);
            check("halt_pc", prog_addr, pc_m);
            check("halt_ctrl", obs_ctrl, 21'd0);
            check_retired();
        end

        do_reset();
        run = 1;
        exec_one("ldi3");
        zero_flag = 1;
        exec_one("add3");
        zero_flag = 0;
        exec_one("jz3");
        sb.push_back(exp_ctrl(rom[pc_m]));
        @(posedge clk); @(negedge clk);
        check("st_mid_ctrl", obs_ctrl, sb.pop_front());
        reset = 1;
        #1;
        check("midrst_wr", write_ram_enable, 1'b0);
        check("midrst_pc", prog_addr, 8'h00);
        check("midrst_halted", halted, 1'b0);
        model_reset();
        check_retired();
        @(negedge clk);
        reset = 0;
        exec_one("ldi4");

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the accumulator-style processor; sits directly upstream of data_unit and drives all of its control inputs.
- Fetches 16-bit instructions from a synchronous program ROM, decodes them into data_unit control fields, captures ALU flags, and resolves jumps and conditional branches.
- Two cycles per instruction (FETCH, EXECUTE); terminal HALT state.

Parameters:
- PC_WIDTH, 8, program counter and program address width.
- INSTR_WIDTH, 16, instruction word width; fixed format below, values other than 16 are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run  in  1  permits leaving FETCH; sampled only in FETCH.
- prog_addr  out  PC_WIDTH  program ROM address; always equals pc.
- prog_data  in  16  ROM read data; valid one cycle after prog_addr.
- zero_flag, carrier_flag, negative_flag  in  1 each  data_unit flags.
- load_enable  out  1  register-file write.
- operation_select  out  3  ALU op.
- a_select, b_select, destination_select  out  2 each  register selects.
- constant_in  out  8  immediate.
- mb_select  out  1  B operand = constant.
- md_select  out  1  writeback from RAM.
- write_ram_enable  out  1  RAM write.
- halted  out  1  high in HALT.

Behaviour:
- Instruction format: [15:12] opcode, [11:10] dst, [9:8] a, [7:6] b, [7:0] imm.
- Opcodes: 0000-0111 ALU reg-reg, operation_select=opcode[2:0]; 1000 LDI; 1001 LD; 1010 ST; 1011 JMP; 1100 JZ; 1101 JC; 1110 JN; 1111 HALT.
- Reset: state=FETCH, pc=0, stored flags=0, halted=0, every control output 0.
- FETCH: all control outputs 0. If run=1, go to EXECUTE; otherwise stay and hold pc.
- EXECUTE: decode prog_data combinationally; control outputs are valid for exactly this cycle. Next state is FETCH, or HALT for opcode 1111.
- ALU: load_enable=1, mb=0, md=0, selects from fields.
- LDI: operation_select=100, mb=1, constant_in=imm, load_enable=1, a/b=0.
- LD: md=1, load_enable=1, a/b/dst from fields.
- ST: write_ram_enable=1, load_enable=0, a/b from fields.
- JMP, Jcc, HALT: all enables 0.
- Flag capture: at the end of EXECUTE for ALU, LDI and LD, store zero/carrier/negative_flag. No other opcode changes the stored flags.
- PC update at end of EXECUTE:
  - JMP: pc=imm[PC_WIDTH-1:0].
  - JZ/JC/JN: taken on the corresponding stored flag (the value before this instruction), pc=imm; not taken, pc+1.
  - All other opcodes: pc+1, wrapping modulo 2^PC_WIDTH.
- HALT: pc not incremented; halted=1; outputs 0; stays until reset; run ignored.
- Reset asserted mid-EXECUTE: outputs drop to 0 immediately; no flag capture, no pc update.
- Jump to self: legal; loops indefinitely.

Optional Feature:
- Macro: CONTROL_UNIT_RETIRE_COUNT_EN.
- Defined: adds output retired_count [15:0]. Reset 0; increments at the end of each EXECUTE (including HALT); wraps at 0xFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package control_pkg: opcode localparams, ALU operation_select codes (ADD 000, SUB 001, AND 010, OR 011, PASS_B 100), state encoding, field bit positions.
- One sub-module, instruction_decoder: purely combinational opcode/field to control-vector mapping. Enabled only when state=EXECUTE.

Test Plan:
- Reset, run=1, ROM[0]=0x800A (LDI r0,10): second cycle shows operation_select=100, mb_select=1, constant_in=10, dst=00, load_enable=1; prog_addr=1 on cycle 3.
- ROM[1]=0x0040 (ADD r0,r0,r1): EXECUTE shows op=000, a=00, b=01, mb=0, load_enable=1. With zero_flag=1 driven, stored Z=1. ROM[2]=0xC010 (JZ 0x10): prog_addr=0x10 next. Repeat with zero_flag=0: prog_addr=3.
- ROM=0xA040 (ST): write_ram_enable=1, load_enable=0, b_select=01; then ROM=0x9040 (LD): md_select=1, load_enable=1.
- JMP 0xFF, ROM[0xFF]=LDI: after LDI, prog_addr wraps to 0x00. Hold run=0 in FETCH for 5 cycles: pc stable, all enables 0.
- ROM=0xF000 (HALT): halted=1, pc frozen, outputs 0 over 10 cycles with run toggling. Assert reset during an ST EXECUTE: write_ram_enable falls immediately, pc=0, halted=0.
- With CONTROL_UNIT_RETIRE_COUNT_EN: after 3 instructions ending in HALT, retired_count=3 and stays 3.
